// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: decode-stage bundle, request side (in_*) and result side (out_*); slave = generator, master = driver
interface imm_gen_pipe_if #(parameter int XLEN = 32, parameter int TAG_W = 5);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      ins;
  logic [2:0]       imm_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic             out_ill;
  logic [TAG_W-1:0] out_tag;
  modport slave (input in_valid, ins, imm_sel, in_tag, out_ready,
                 output in_ready, out_valid, out_imm, out_ill, out_tag);
  modport master (output in_valid, ins, imm_sel, in_tag, out_ready,
                  input in_ready, out_valid, out_imm, out_ill, out_tag);
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered I/S/B/J/U/SHAMT immediate generator with 2-entry skid, flush and saturating illegal count (clk, rst_n, flush, ill_cnt, bus)
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  output logic [ILL_CNT_W-1:0] ill_cnt,
  imm_gen_pipe_if.slave        bus
);
  logic             w_ill, w_acc, w_a_free, w_a_valid_nxt, w_b_valid_nxt;
  logic [XLEN-1:0]  w_imm;
  logic             r_a_valid, r_b_valid, r_ready, r_a_ill, r_b_ill;
  logic [XLEN-1:0]  r_a_imm, r_b_imm;
  logic [TAG_W-1:0] r_a_tag, r_b_tag;
  logic [ILL_CNT_W-1:0] r_ill_cnt;
  always_comb begin
    w_ill = bus.imm_sel == 3'b000 || bus.imm_sel == 3'b111;
    w_imm = bus.imm_sel == 3'b001 ? {{(XLEN-12){bus.ins[31]}}, bus.ins[31:20]} :
            bus.imm_sel == 3'b010 ? {{(XLEN-12){bus.ins[31]}}, bus.ins[31:25], bus.ins[11:7]} :
            bus.imm_sel == 3'b011 ? {{(XLEN-12){bus.ins[31]}}, bus.ins[7], bus.ins[30:25], bus.ins[11:8], 1'b0} :
            bus.imm_sel == 3'b100 ? {{(XLEN-20){bus.ins[31]}}, bus.ins[19:12], bus.ins[20], bus.ins[30:21], 1'b0} :
            bus.imm_sel == 3'b101 ? {{(XLEN-31){bus.ins[31]}}, bus.ins[30:12], 12'b0} :
            bus.imm_sel == 3'b110 ? {{(XLEN-6){1'b0}}, XLEN == 64 && bus.ins[25], bus.ins[24:20]} :
            '0;
    w_acc = bus.in_valid && r_ready && !flush;
    w_a_free = !r_a_valid || (r_a_valid && bus.out_ready);
    // a freed output slot drains the skid first; the skid fills only while the output slot is held
    w_a_valid_nxt = !flush && (w_a_free ? (r_b_valid || w_acc) : 1'b1);
    w_b_valid_nxt = !flush && !w_a_free && (r_b_valid || w_acc);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_ready   <= 1'b0;
      r_a_imm   <= '0;
      r_a_ill   <= 1'b0;
      r_a_tag   <= '0;
      r_b_imm   <= '0;
      r_b_ill   <= 1'b0;
      r_b_tag   <= '0;
      r_ill_cnt <= '0;
    end else begin
      r_a_valid <= w_a_valid_nxt;
      r_b_valid <= w_b_valid_nxt;
      r_ready   <= !w_b_valid_nxt;
      if (w_a_free && r_b_valid) begin
        r_a_imm <= r_b_imm;
        r_a_ill <= r_b_ill;
        r_a_tag <= r_b_tag;
      end else if (w_a_free && w_acc) begin
        r_a_imm <= w_imm;
        r_a_ill <= w_ill;
        r_a_tag <= bus.in_tag;
      end
      if (!w_a_free && w_acc) begin
        r_b_imm <= w_imm;
        r_b_ill <= w_ill;
        r_b_tag <= bus.in_tag;
      end
      if (w_acc && w_ill && !(&r_ill_cnt)) r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
    end
  end
  assign bus.in_ready  = r_ready;
  assign bus.out_valid = r_a_valid;
  assign bus.out_imm   = r_a_imm;
  assign bus.out_ill   = r_a_ill;
  assign bus.out_tag   = r_a_tag;
  assign ill_cnt       = r_ill_cnt;
endmodule
